// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-7-segment scanner.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package seg_pkg;

   // One BCD digit.
   typedef logic [3:0] bcd_t;

   // Number of digit slots scanned, including the always-blank slot.
   localparam int NUM_DIGITS = 4;

   // Active-low segment codes, bit7 = dp (kept off), bits6..0 = g..a.
   localparam logic [7:0] SEG_D0    = 8'hC0;
   localparam logic [7:0] SEG_D1    = 8'hF9;
   localparam logic [7:0] SEG_D2    = 8'hA4;
   localparam logic [7:0] SEG_D3    = 8'hB0;
   localparam logic [7:0] SEG_D4    = 8'h99;
   localparam logic [7:0] SEG_D5    = 8'h92;
   localparam logic [7:0] SEG_D6    = 8'h82;
   localparam logic [7:0] SEG_D7    = 8'hF8;
   localparam logic [7:0] SEG_D8    = 8'h80;
   localparam logic [7:0] SEG_D9    = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Map a BCD digit to its segment pattern; non-decimal codes show blank.
   function automatic logic [7:0] seg_encode(input bcd_t d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_D0;
         4'd1:    s = SEG_D1;
         4'd2:    s = SEG_D2;
         4'd3:    s = SEG_D3;
         4'd4:    s = SEG_D4;
         4'd5:    s = SEG_D5;
         4'd6:    s = SEG_D6;
         4'd7:    s = SEG_D7;
         4'd8:    s = SEG_D8;
         4'd9:    s = SEG_D9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: a digit of 5 or more gets +3 before the shift.
   function automatic bcd_t dd_adjust(input bcd_t d);
      return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter with a held display register.
// Latency: load accepted in cycle N, busy for N+1..N+8, result visible from N+9.
// Backpressure: load while busy is dropped, not queued; no output handshake.
module bin2bcd8
   import seg_pkg::*;
(
   input  logic        clkin,
   input  logic        rst_n,
   input  logic [7:0]  num,
   input  logic        load,
   output logic        busy,
   output logic [11:0] disp
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  sr, sr_nxt;        // remaining binary bits, MSB shifted out first
   logic [11:0] acc, acc_nxt;      // BCD accumulator: hundreds, tens, units
   logic [2:0]  iter, iter_nxt;    // shift iteration 0..7
   logic [11:0] disp_nxt;
   logic [11:0] acc_adj;
   logic [19:0] shifted;

   // Add-3 correction on every nibble, then one left shift of {bcd, binary}.
   always_comb begin
      acc_adj = {dd_adjust(acc[11:8]), dd_adjust(acc[7:4]), dd_adjust(acc[3:0])};
      shifted = {acc_adj, sr} << 1;
   end

   // State, working registers and display register; reset aborts a conversion.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         sr    <= '0;
         acc   <= '0;
         iter  <= '0;
         disp  <= '0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         acc   <= acc_nxt;
         iter  <= iter_nxt;
         disp  <= disp_nxt;
      end
   end

   // Capture on an idle load, then 8 shift cycles; the last one commits the display.
   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      acc_nxt   = acc;
      iter_nxt  = iter;
      disp_nxt  = disp;
      case (state)
         S_IDLE: begin
            if (load) begin
               sr_nxt    = num;
               acc_nxt   = '0;
               iter_nxt  = '0;
               state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            acc_nxt  = shifted[19:8];
            sr_nxt   = shifted[7:0];
            iter_nxt = iter + 3'd1;
            if (iter == 3'd7) begin
               disp_nxt  = shifted[19:8];
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_CONV);

endmodule

// File: rtl/bin2seg_scan.sv
// 8-bit value to multiplexed 4-slot 7-segment display; SEG_LZB_EN enables leading-zero blanking.
// Latency: new value on the display 9 cycles after an accepted load; scan slot every SCAN_DIV cycles.
// Backpressure: busy high during conversion, loads then ignored; scanning never stalls.
module bin2seg_scan
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000
)(
   input  logic       clkin,
   input  logic       rst_n,
   input  logic [7:0] num,
   input  logic       load,
   output logic       busy,
   output logic [3:0] DIG,
   output logic [7:0] Y
);

   localparam int          IDX_W    = $clog2(NUM_DIGITS);
   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0]      div_cnt;
   logic [IDX_W-1:0] idx;
   logic [11:0]      disp;
   logic             blank_hun;
   logic             blank_ten;

   bin2bcd8 u_bin2bcd8 (
      .clkin (clkin),
      .rst_n (rst_n),
      .num   (num),
      .load  (load),
      .busy  (busy),
      .disp  (disp)
   );

   // Free-running slot timer; the digit index steps on each terminal count.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         idx     <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         idx     <= idx + IDX_W'(1);
      end else begin
         div_cnt <= div_cnt + 16'd1;
      end
   end

`ifdef SEG_LZB_EN
   assign blank_hun = (disp[11:8] == 4'd0);
   assign blank_ten = blank_hun && (disp[7:4] == 4'd0);
`else
   assign blank_hun = 1'b0;
   assign blank_ten = 1'b0;
`endif

   // Digit select and segments both come from the registered index and display.
   always_comb begin
      DIG = 4'b1111;
      Y   = SEG_BLANK;
      case (idx)
         IDX_W'(0): begin
            DIG = 4'b1110;
            Y   = seg_encode(disp[3:0]);
         end
         IDX_W'(1): begin
            DIG = 4'b1101;
            Y   = blank_ten ? SEG_BLANK : seg_encode(disp[7:4]);
         end
         IDX_W'(2): begin
            DIG = 4'b1011;
            Y   = blank_hun ? SEG_BLANK : seg_encode(disp[11:8]);
         end
         default: begin
            DIG = 4'b0111;
            Y   = SEG_BLANK;
         end
      endcase
   end

endmodule

// File: tb/tb_bin2seg_scan.sv
// Scoreboard bench for bin2seg_scan with SCAN_DIV=4.
// Stimulus pushes the expected 4-slot pattern {slot3,slot2,slot1,slot0} per load;
// the monitor pops one on each busy fall (or explicit request) and scans DIG/Y.
module tb_bin2seg_scan;

   logic       clkin = 1'b0;
   logic       rst_n;
   logic [7:0] num;
   logic       load;
   logic       busy;
   logic [3:0] DIG;
   logic [7:0] Y;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb[$];
   bit          scan_req = 1'b0;

`ifdef SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   localparam logic [31:0] E173 = {8'hFF, 8'hF9, 8'hF8, 8'hB0};
   localparam logic [31:0] E255 = {8'hFF, 8'hA4, 8'h92, 8'h92};
   localparam logic [31:0] E000 = LZB ? {8'hFF, 8'hFF, 8'hFF, 8'hC0} : {8'hFF, 8'hC0, 8'hC0, 8'hC0};
   localparam logic [31:0] E007 = LZB ? {8'hFF, 8'hFF, 8'hFF, 8'hF8} : {8'hFF, 8'hC0, 8'hC0, 8'hF8};
   localparam logic [31:0] E200 = {8'hFF, 8'hA4, 8'hC0, 8'hC0};
   localparam logic [31:0] E042 = LZB ? {8'hFF, 8'hFF, 8'h99, 8'hA4} : {8'hFF, 8'hC0, 8'h99, 8'hA4};
   localparam logic [31:0] E137 = {8'hFF, 8'hF9, 8'hB0, 8'hF8};

   bin2seg_scan #(.SCAN_DIV(4)) dut (
      .clkin (clkin),
      .rst_n (rst_n),
      .num   (num),
      .load  (load),
      .busy  (busy),
      .DIG   (DIG),
      .Y     (Y)
   );

   always #5 clkin = ~clkin;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   function automatic int dig_idx(input logic [3:0] d);
      case (d)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   function automatic logic [3:0] dig_for(input int i);
      case (i)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // Issue a load at the current negedge (cycle N) and check busy over N..N+9.
   // A nonzero ign drives a stray load of 9 in busy cycle ign, which must be dropped.
   // Returns at the negedge of cycle N+9, so a chained call is a back-to-back load.
   task automatic conv(input logic [7:0] n, input logic [31:0] e, input int ign);
      logic [9:0] pat;
      sb.push_back(e);
      num     = n;
      load    = 1'b1;
      pat[9]  = busy;
      for (int i = 1; i < 10; i++) begin
         @(negedge clkin);
         pat[9-i] = busy;
         if (i == ign) begin
            num  = 8'd9;
            load = 1'b1;
         end else begin
            load = 1'b0;
         end
      end
      check($sformatf("busy_window_%0d", n), {22'd0, pat}, {22'd0, 10'b0111111110});
   endtask

   // Monitor: on each result event, pop the expectation and collect all four slots.
   initial begin : monitor
      logic        busy_q;
      bit          pending;
      logic [31:0] e;
      logic [3:0]  seen;
      int          n;
      int          k;
      busy_q  = 1'b0;
      pending = 1'b0;
      forever begin
         if (!pending) begin
            @(negedge clkin);
            pending  = (rst_n && busy_q && !busy) || scan_req;
            busy_q   = busy;
            scan_req = 1'b0;
         end
         if (pending) begin
            pending = 1'b0;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: result event with no expectation queued");
            end else begin
               e    = sb.pop_front();
               seen = 4'b0000;
               n    = 0;
               forever begin
                  k = dig_idx(DIG);
                  if (k < 0) begin
                     checks++;
                     errors++;
                     $display("FAIL dig_onehot: got %b, want one low bit", DIG);
                  end else if (!seen[k]) begin
                     seen[k] = 1'b1;
                     check($sformatf("y_slot%0d_exp%h", k, e), {24'd0, Y}, {24'd0, e[8*k +: 8]});
                  end
                  if (seen == 4'b1111) break;
                  if (n == 16) begin
                     checks++;
                     errors++;
                     $display("FAIL scan_timeout: slots seen %b, want 1111", seen);
                     break;
                  end
                  @(negedge clkin);
                  n++;
                  if (rst_n && busy_q && !busy) pending = 1'b1;
                  busy_q = busy;
                  if (pending) break;
               end
            end
         end
      end
   end

   // Stimulus.
   initial begin : stim
      bit late_busy;
      rst_n = 1'b0;
      load  = 1'b0;
      num   = 8'd0;

      // Reset state, including across clock edges.
      #3;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_dig",  {28'd0, DIG},  {28'd0, 4'b1110});
      check("rst_y",    {24'd0, Y},    {24'd0, 8'hC0});
      repeat (3) @(negedge clkin);
      check("rst_dig_hold", {28'd0, DIG}, {28'd0, 4'b1110});
      rst_n = 1'b1;

      // Scan sequence: one slot per 4 cycles, wrapping 0111 -> 1110.
      for (int k = 1; k <= 20; k++) begin
         @(negedge clkin);
         check($sformatf("scan_dig_k%0d", k), {28'd0, DIG}, {28'd0, dig_for((k / 4) % 4)});
      end

      conv(8'd173, E173, 0);
      repeat (20) @(negedge clkin);
      conv(8'd255, E255, 0);
      repeat (20) @(negedge clkin);
      conv(8'd0, E000, 0);
      repeat (20) @(negedge clkin);
      conv(8'd7, E007, 0);
      repeat (20) @(negedge clkin);
      conv(8'd200, E200, 3);
      repeat (20) @(negedge clkin);
      conv(8'd42, E042, 0);
      conv(8'd137, E137, 0);
      repeat (20) @(negedge clkin);

      // Reset in busy cycle 5 of a conversion of 99.
      num  = 8'd99;
      load = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clkin);
         load = 1'b0;
      end
      check("abort_precond_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_dig",  {28'd0, DIG},  {28'd0, 4'b1110});
      check("abort_y",    {24'd0, Y},    {24'd0, 8'hC0});
      repeat (2) @(negedge clkin);
      rst_n = 1'b1;
      sb.push_back(E000);
      scan_req  = 1'b1;
      late_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clkin);
         if (busy) late_busy = 1'b1;
      end
      check("abort_no_late_busy", {31'd0, late_busy}, 32'd0);
      sb.push_back(E000);
      scan_req = 1'b1;
      repeat (20) @(negedge clkin);

      check("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bin2seg_scan.md
BIN2SEG_SCAN -- requirements
Module: bin2seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clkin cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port clkin  input  1  clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port num  input  8  unsigned binary value to display.
REQ-005 SHALL have port load  input  1  single-cycle strobe to capture num.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port DIG  output  4  digit select, one-hot, active-low; bit0 = units.
REQ-008 SHALL have port Y  output  8  segments, active-low; bit7 = dp (always 1), bits6..0 = g..a.

Function
REQ-009 SHALL sample load on each clkin rising edge, and accept it only when busy=0; load while busy=1 is ignored, with no queueing.
REQ-010 On an accepted load in cycle N, SHALL capture num and raise busy for cycles N+1..N+8.
REQ-011 SHALL convert using sequential double-dabble: 8 shift iterations, one per busy cycle, with add-3 applied to any BCD nibble >=5 before each shift.
REQ-012 SHALL update the 12-bit display register (hundreds, tens, units) atomically at the end of cycle N+8, visible from cycle N+9; busy SHALL be 0 in cycle N+9.
REQ-013 Back-to-back operation: a load in cycle N+9 SHALL be accepted; the display holds the prior value until the new conversion completes.
REQ-014 SHALL run a scan divider counting 0..SCAN_DIV-1; at terminal count it wraps to 0 and the 2-bit digit index advances 0->1->2->3->0.
REQ-015 The divider and digit index SHALL run freely and SHALL be unaffected by load or busy.
REQ-016 DIG SHALL be 1110/1101/1011/0111 for index 0/1/2/3.
REQ-017 Y SHALL show units/tens/hundreds for index 0/1/2; index 3 SHALL always be blank (8'hFF).
REQ-018 SHALL use codes 0..9 = C0,F9,A4,B0,99,92,82,F8,80,90; blank = FF.
REQ-019 DIG and Y SHALL both be decoded from the same registered index and display register, so they change in the same cycle.
REQ-020 SHALL show the whole range 0..255 with no overflow; no input value is illegal.

Reset
REQ-021 rst_n low SHALL asynchronously clear: divider, index (=0), display register (=000), busy (=0) and the conversion state.
REQ-022 Outputs in reset SHALL be DIG=1110, Y=C0, busy=0.
REQ-023 Reset during a conversion SHALL abort it; the display SHALL read 000 and the captured value SHALL be discarded.
REQ-024 After rst_n rises, the first accepted load SHALL be on the first clkin edge at which load=1.

Configuration
REQ-025 Macro SEG_LZB_EN defined: leading-zero blanking; hundreds blank when 0; tens blank when hundreds=0 and tens=0; units always shown.
REQ-026 Macro SEG_LZB_EN undefined: all three digits SHALL be shown, including leading zeros.
REQ-027 Scan timing and DIG SHALL be identical in both builds.

Structure
REQ-028 Package seg_pkg SHALL hold: the 10 segment codes, SEG_BLANK=8'hFF, NUM_DIGITS=4, and the BCD digit typedef (4-bit).
REQ-029 SHALL instantiate exactly one sub-module, bin2bcd8, containing the sequential double-dabble, load/busy handshake and display register.
REQ-030 Scan divider, index and segment decode SHALL reside in the top module.

Verification (bench SCAN_DIV=4)
REQ-031 Reset: rst_n low -> DIG=1110, Y=C0, busy=0; after release, DIG advances every 4 cycles and wraps from 0111 to 1110.
REQ-032 load num=173 in cycle N -> busy=1 for N+1..N+8; from N+9, Y reads B0/F8/F9/FF on index 0/1/2/3.
REQ-033 load num=255 -> F9... no: Y reads 92/92/A4/FF; load num=0 -> C0/C0/C0/FF without the macro, C0/FF/FF/FF with SEG_LZB_EN.
REQ-034 load 200, then load 9 in busy cycle 3 -> second load ignored; display ends at 200 (C0/C0/A4).
REQ-035 num=7 -> with SEG_LZB_EN: F8/FF/FF/FF; without: F8/C0/C0/FF.
REQ-036 rst_n pulsed low in busy cycle 5 of a load of 99 -> busy=0 immediately; display 000; no later update to 99.
